pct_log_seq: RTL
================

PCT_LOG_SEQ -- requirements
Module: pct_log_seq

Interface
REQ-001 Parameter DECADES, default 4: decades of log scale; legal 1..4.
REQ-002 Parameter OUT_W, default 14: output width; SHALL satisfy 2^OUT_W > 10^DECADES.
REQ-003 Parameter FRAC, default 24: fractional bits of the internal fixed-point accumulator.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 in_valid  in  1  request carries a new percentage.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 x  in  7  linear percentage, legal 0..100.
REQ-009 out_valid  out  1  result held on y/err.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 y  out  OUT_W  log-scale result, 1..10^DECADES.
REQ-012 err  out  1  request had x > 100.

Function
REQ-013 Result SHALL equal 10^(x*DECADES/100), computed iteratively, not from a table.
REQ-014 Ratio constant R = round(10^(DECADES/100) * 2^FRAC), computed at elaboration.
REQ-015 Accumulator width OUT_W+FRAC+1; loaded with 1.0 (1 << FRAC) on accept.
REQ-016 Each RUN cycle: acc <= (acc*R + 2^(FRAC-1)) >> FRAC; step counter decrements.
REQ-017 y = (acc + 2^(FRAC-1)) >> FRAC, saturated to 2^OUT_W-1.
REQ-018 Rounded y SHALL be within ±1 of round(10^(x*DECADES/100)) for all legal x; bit-exact to REQ-015..017.
REQ-019 States: IDLE, RUN, DONE.
REQ-020 IDLE: in_ready=1; accept when in_valid=1; x<=100 -> RUN with count=x; x>100 -> DONE with y=0, err=1.
REQ-021 RUN: in_ready=0; count=0 -> DONE, y registered from acc; otherwise iterate.
REQ-022 Latency: accept at cycle 0; out_valid rises at cycle x+2 (x=0 -> cycle 2; error -> cycle 1).
REQ-023 DONE: out_valid=1; y/err stable until out_valid&&out_ready, then -> IDLE.
REQ-024 in_ready SHALL be 0 in RUN and DONE; no accept while a result is pending (no overlap).
REQ-025 in_valid held through RUN/DONE SHALL NOT be re-accepted until back in IDLE.
REQ-026 x sampled only at acceptance; later x changes are ignored.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, y=0, err=0, count=0, acc=0.
REQ-028 Reset during RUN or DONE SHALL abort; the pending result is discarded and never presented.

Structure
REQ-029 Shared package pct_log_pkg: state enum, ratio function/constant R(DECADES,FRAC), MAX_PCT=100.
REQ-030 One sub-module pct_log_mulstep: combinational acc*R with rounding shift; FSM, counter and output register in top.
REQ-031 Only one multiplier instance; no lookup table.

Verification
REQ-032 DECADES=4: x=0 -> y=1, err=0, out_valid at cycle 2; x=50 -> y=100 at cycle 52; x=75 -> y=1000; x=100 -> y=10000 at cycle 102.
REQ-033 x=101 and x=127 -> y=0, err=1, out_valid at cycle 1; next legal request is processed normally.
REQ-034 out_ready held low 10 cycles in DONE -> y/err stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-035 rst pulsed at cycle 20 of x=60 -> out_valid never rises; in_ready=1 after release; next x=25 -> y=10.
REQ-036 Sweep x=0..100 for DECADES=1..4 -> y within ±1 of round(10^(x*DECADES/100)); back-to-back requests with out_ready=1.

Source files
------------

// File: rtl/pct_log_pkg.sv
// Shared types and elaboration-time constants for the percent-to-log-scale sequencer.
package pct_log_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } pct_state_t;

  localparam int MAX_PCT = 100;

  // round(10^(decades/100) * 2^frac), evaluated with an exp() series since
  // 10^t = e^(t*ln10) and t*ln10 stays below 0.1, so 16 terms are exact in double precision.
  function automatic longint pct_ratio(input int decades, input int frac);
    real t;
    real term;
    real sum;
    t    = real'(decades) * 2.302585092994046 / 100.0;
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k < 16; k++) begin
      term = term * t / real'(k);
      sum  = sum + term;
    end
    return longint'(sum * (2.0 ** frac));
  endfunction

endpackage

// File: rtl/pct_log_mulstep.sv
// One geometric step of the accumulator: (acc * coef + half) >> FRAC.
module pct_log_mulstep #(
  parameter int AW     = 39,
  parameter int COEF_W = 26,
  parameter int FRAC   = 24
) (
  input  logic [AW-1:0]     acc,
  input  logic [COEF_W-1:0] coef,
  output logic [AW-1:0]     acc_next
);

  localparam int PW = AW + COEF_W;

  function automatic logic [AW-1:0] round_shift(input logic [PW-1:0] p);
    logic [PW-1:0] s;
    s = p + (PW'(1) << (FRAC - 1));
    return AW'(s >> FRAC);
  endfunction

  logic [PW-1:0] prod;

  assign prod     = PW'(acc) * PW'(coef);
  assign acc_next = round_shift(prod);

endmodule

// File: rtl/pct_log_seq.sv
// Iterative linear-percent to log-scale converter: y = 10^(x*DECADES/100),
// built by raising a fixed-point ratio to the x-th power one multiply per cycle.
module pct_log_seq
  import pct_log_pkg::*;
#(
  parameter int DECADES = 4,
  parameter int OUT_W   = 14,
  parameter int FRAC    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             err
);

  localparam int AW     = OUT_W + FRAC + 1;
  localparam int COEF_W = FRAC + 2;
  localparam logic [COEF_W-1:0] R     = COEF_W'(pct_ratio(DECADES, FRAC));
  localparam logic [6:0]        MAX_X = 7'(MAX_PCT);

  function automatic logic [OUT_W-1:0] sat_round(input logic [AW-1:0] a);
    logic [AW:0] s;
    s = {1'b0, a} + ((AW + 1)'(1) << (FRAC - 1));
    if (|s[AW:FRAC+OUT_W])
      return '1;
    return s[FRAC+OUT_W-1:FRAC];
  endfunction

  pct_state_t      state, state_nxt;
  logic [6:0]      count;
  logic [AW-1:0]   acc, acc_next;

  pct_log_mulstep #(
    .AW    (AW),
    .COEF_W(COEF_W),
    .FRAC  (FRAC)
  ) u_mulstep (
    .acc     (acc),
    .coef    (R),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (x > MAX_X) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (count == 7'd0)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only change on accept (error path) or at the end of RUN,
  // so y/err stay frozen for the whole DONE hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      acc   <= '0;
      y     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (x > MAX_X) begin
              y   <= '0;
              err <= 1'b1;
            end else begin
              count <= x;
              acc   <= AW'(1) << FRAC;
            end
          end
        end
        ST_RUN: begin
          if (count == 7'd0) begin
            y   <= sat_round(acc);
            err <= 1'b0;
          end else begin
            acc   <= acc_next;
            count <= count - 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
